// File: rtl/uart_tx_strobed_pkg.sv
// Shared UART definitions: transmitter state encoding and parity modes.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      START,
      DATA,
      PAR,
      STOP
   } uart_tx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_strobed_if.sv
// Valid/ready word handshake between an upstream producer and the transmitter.
interface uart_tx_strobed_if #(
   parameter int DATA_BITS = 8
);

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );

endinterface

// File: rtl/uart_tx_strobed.sv
// Serial frame transmitter paced by an external one-cycle baud_tick strobe.
// Frame: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_strobed
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PARITY_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               baud_tick,
   uart_tx_strobed_if.slave   bus,
   output logic               busy,
   output logic               tx
);

   localparam int CW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

   uart_tx_state_t       state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      tx_d    = tx_q;
      unique case (state_q)
         IDLE: begin
            // a tick on the acceptance edge is deliberately not consumed
            if (bus.tx_valid) begin
               shift_d = bus.tx_data;
               par_d   = (^bus.tx_data) ^ (PARITY == PARITY_ODD);
               cnt_d   = '0;
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (baud_tick) begin
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (cnt_q == LAST_DATA) begin
                  cnt_d = '0;
                  if (PARITY != PARITY_NONE) begin
                     state_d = PAR;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  tx_d  = shift_d[0];
               end
            end
         end
         PAR: begin
            if (baud_tick) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (cnt_q == LAST_STOP) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign bus.tx_ready = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign tx           = tx_q;

endmodule

// File: doc/uart_tx_strobed.md
# uart_tx_strobed

Tick-paced serial transmitter: accepts a parallel word over a valid/ready handshake and shifts it out as an asynchronous-serial frame. The frame is start bit, data LSB-first, optional parity, then stop bit(s). Bit timing is not generated here. The block sits directly downstream of the team's pulse generator and consumes its one-cycle `out` pulse as `baud_tick`, one pulse per bit period.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  reset: synchronous, active-low; registers reset on a posedge where `rst`==0.
- `baud_tick`  in  1  one-cycle bit-period strobe from the pulse generator.
- `tx_valid`  in  1  upstream has a word.
- `tx_data`  in  DATA_BITS  word; sampled only on acceptance.
- `tx_ready`  out  1  block can accept a word.
- `busy`  out  1  frame armed or in progress.
- `tx`  out  1  serial line, registered, idle high.

## Operation
- States: IDLE, ARMED, START, DATA, PAR, STOP.
- Acceptance happens on a posedge with `tx_valid & tx_ready`.
  - `tx_data` loads the shift register.
  - Parity = ^`tx_data`, inverted when odd.
  - Bit counter clears.
  - State goes to ARMED.
- `tx_valid` while not ready is ignored: no capture, no side effects. `tx_data` may change freely after acceptance.
- Transitions only ever happen on `baud_tick`, except acceptance.
  - ARMED → START; `tx` ← 0.
  - START → DATA; `tx` ← shift[0].
  - DATA, per tick: shift right. After DATA_BITS ticks in DATA, go to PAR if PARITY≠0, else STOP. `tx` ← the new state's bit.
  - PAR → STOP; `tx` ← 1.
  - STOP: counts STOP_BITS ticks, then → IDLE; `tx` stays 1.
- `tx` updates on the same edge as the state change, so every bit, including the last stop bit, lasts exactly one tick period.
- Bit counter width is $clog2(DATA_BITS+1); it must not wrap before the compare.

## Timing
- Reset values: state IDLE, `tx`=1, `tx_ready`=1, `busy`=0, shift register and counter 0.
- `tx_ready` = (state==IDLE), combinational from the state register.
- `busy` = ~IDLE.
- Acceptance at edge n: `tx_ready` is 0 and `busy` is 1 from n+1 onward.
- A `baud_tick` coinciding with the acceptance edge is ignored; arming needs a later tick. The start bit therefore begins on the first tick strictly after acceptance.
- Latency from acceptance to `tx` falling is 1 to P cycles for tick period P.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) tick periods.
- Back-to-back: after the final stop tick the block is in IDLE with `tx_ready`=1 for the next cycle. A word accepted then starts on the next-but-one tick, giving at least one extra idle-high period.
- `baud_tick` held high continuously is legal: the frame advances one bit per clock.
- Reset mid-frame: the frame is dropped, `tx`=1 at the next edge, and no partial bits resume.
- `baud_tick` during IDLE has no effect.

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` enum (IDLE, ARMED, START, DATA, PAR, STOP).
  - Parity constants PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2.
- No sub-module. The pulse generator is instantiated by the parent, with its `out` wired to `baud_tick`. The parent sets its tick count for clk/baud.

## Test plan
- Reset and idle: `rst`=0 for 2 cycles, then 1 with no valid → `tx`=1, `tx_ready`=1, `busy`=0; ticks change nothing.
- Basic frame, defaults, ticks every 4 clocks, send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; `tx_ready` returns to 1 after 40 clocks of frame.
- Parity: PARITY=1 with 0xA5 → parity bit 0. PARITY=2 → 1. STOP_BITS=2 → stop high for 8 clocks.
- Handshake:
  - `tx_valid` held with 0x3C then 0xC3 → two complete frames in order.
  - `tx_data` changed to 0xFF after acceptance → first frame still carries 0x3C.
  - Valid during busy → not captured.
- Simultaneous tick and accept: a tick on the acceptance edge is ignored, so start begins at the following tick; continuous `baud_tick`=1 sends a frame at one bit per clock.
- Reset mid-frame: `rst`=0 during DATA bit 3 → next cycle `tx`=1, state IDLE, `tx_ready`=1, and no residual bits afterward.
